// File: rtl/data_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_pkg
// Shared constants for the CPU/DMA data-bus arbiter: FSM state encoding,
// default bus widths and counter widths.
// No ports (package).
// -----------------------------------------------------------------------------
package data_bus_pkg;

  // Arbiter FSM states
  localparam logic [0:0] S_SHARE = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  // Default bus geometry
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  // Starvation counter holds 0..MAX_STARVE (MAX_STARVE <= 15)
  localparam int STARVE_W = 4;

  // Burst beat counter holds 0..MAX_BURST-1 (MAX_BURST <= 255)
  localparam int BURST_W = 8;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter_if
// Bundles the CPU (m0), DMA (m1) and crossbar-side (s_*) signals of the
// data-bus arbiter.
//   modport slave  : the arbiter's view (takes requests, drives grants/slave bus)
//   modport master : the environment's view (drives requests, returns s_rdata)
// Parameters: AW address width, DW data width.
// -----------------------------------------------------------------------------
interface data_bus_arbiter_if
  import data_bus_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  // CPU data port
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_wen;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_stall;
  // DMA master
  logic          m1_req;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic          m1_wen;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic [DW-1:0] m1_rdata;
  logic          m1_rvalid;
  // Crossbar side
  logic [AW-1:0] s_addr;
  logic          s_wen;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wen, m0_wdata,
    output m0_rdata, m0_stall,
    input  m1_req, m1_lock, m1_addr, m1_wen, m1_wdata,
    output m1_gnt, m1_rdata, m1_rvalid,
    output s_addr, s_wen, s_wdata,
    input  s_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wen, m0_wdata,
    input  m0_rdata, m0_stall,
    output m1_req, m1_lock, m1_addr, m1_wen, m1_wdata,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  s_addr, s_wen,
    input  s_wdata,
    output s_rdata
  );

endinterface

// File: rtl/data_bus_arbiter_mux.sv
// -----------------------------------------------------------------------------
// bus_master_mux
// Combinational select of the crossbar address/write-enable/write-data from
// the two masters according to the grant.
//   i_gnt0/i_gnt1          : grants (at most one high)
//   i_m0_* / i_m1_*        : master address, write enable, write data
//   o_addr/o_wen/o_wdata   : crossbar-side signals
// -----------------------------------------------------------------------------
module bus_master_mux
  import data_bus_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          i_gnt0,
  input  logic          i_gnt1,
  input  logic [AW-1:0] i_m0_addr,
  input  logic          i_m0_wen,
  input  logic [DW-1:0] i_m0_wdata,
  input  logic [AW-1:0] i_m1_addr,
  input  logic          i_m1_wen,
  input  logic [DW-1:0] i_m1_wdata,
  output logic [AW-1:0] o_addr,
  output logic          o_wen,
  output logic [DW-1:0] o_wdata
);

  always_comb begin
    o_addr  = i_m0_addr;
    o_wdata = i_m0_wdata;
    if (i_gnt1) begin
      o_addr  = i_m1_addr;
      o_wdata = i_m1_wdata;
    end
    // Write enable is qualified by the grant so an idle cycle never writes
    o_wen = (i_gnt0 & i_m0_wen) | (i_gnt1 & i_m1_wen);
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
// Shares the single data-memory port between the CPU data port (m0, fixed
// priority) and a DMA master (m1). A starvation counter forces a DMA grant
// after MAX_STARVE consecutive denials; a locked burst lets the DMA hold the
// port for up to MAX_BURST consecutive beats.
//   clk  : system clock (clk_soc)
//   rst  : synchronous reset, active-high
//   bus  : data_bus_arbiter_if.slave (m0_*, m1_*, s_* signals)
// Memory is async-read / write-at-edge, so a granted beat completes in the
// grant cycle. DMA read data is registered and returned one cycle later.
// -----------------------------------------------------------------------------
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MAX_STARVE = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_arbiter_if.slave    bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_STARVE);
  localparam logic [BURST_W-1:0]  BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam bit                  BURST_EN   = (MAX_BURST > 1);

  logic [0:0]          r_state;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [DW-1:0]       r_m1_rdata;
  logic                r_m1_rvalid;

  logic                w_starve_hit;
  logic                w_gnt0;
  logic                w_gnt1;
  logic [AW-1:0]       w_s_addr;
  logic                w_s_wen;
  logic [DW-1:0]       w_s_wdata;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt == STARVE_LIM) ? cnt : cnt + 1'b1;
  endfunction

  assign w_starve_hit = (r_starve_cnt == STARVE_LIM);

  // Grant decision: combinational from state, counter and requests
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_SHARE) begin
      w_gnt0 = bus.m0_req & ~(bus.m1_req & w_starve_hit);
      w_gnt1 = bus.m1_req & ~w_gnt0;
    end else begin
      // Port is owned by the DMA; the CPU waits even if m1 drops its request
      w_gnt1 = bus.m1_req;
    end
  end

  // FSM and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_SHARE;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
    end else if (r_state == S_SHARE) begin
      if (w_gnt1 && bus.m1_lock && BURST_EN) begin
        r_state     <= S_BURST;
        r_burst_cnt <= BURST_W'(1);
      end
      if (w_gnt1 || !bus.m1_req) begin
        r_starve_cnt <= '0;
      end else if (w_gnt0) begin
        r_starve_cnt <= starve_inc(r_starve_cnt);
      end
    end else begin
      r_starve_cnt <= '0;
      // In S_BURST every cycle with m1_req is a granted beat, so the
      // beat-count exit only ever fires on a granted beat.
      if (!bus.m1_req || !bus.m1_lock || (r_burst_cnt == BURST_LAST)) begin
        r_state     <= S_SHARE;
        r_burst_cnt <= '0;
      end else begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

  // DMA read return: captured at the grant edge, valid the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m1_rdata  <= '0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m1_rvalid <= w_gnt1 & ~bus.m1_wen;
      if (w_gnt1 && !bus.m1_wen) begin
        r_m1_rdata <= bus.s_rdata;
      end
    end
  end

  bus_master_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .i_gnt0     (w_gnt0),
    .i_gnt1     (w_gnt1),
    .i_m0_addr  (bus.m0_addr),
    .i_m0_wen   (bus.m0_wen),
    .i_m0_wdata (bus.m0_wdata),
    .i_m1_addr  (bus.m1_addr),
    .i_m1_wen   (bus.m1_wen),
    .i_m1_wdata (bus.m1_wdata),
    .o_addr     (w_s_addr),
    .o_wen      (w_s_wen),
    .o_wdata    (w_s_wdata)
  );

  assign bus.s_addr    = w_s_addr;
  assign bus.s_wen     = w_s_wen;
  assign bus.s_wdata   = w_s_wdata;
  assign bus.m0_rdata  = bus.s_rdata;
  assign bus.m0_stall  = bus.m0_req & ~w_gnt0;
  assign bus.m1_gnt    = w_gnt1;
  assign bus.m1_rdata  = r_m1_rdata;
  assign bus.m1_rvalid = r_m1_rvalid;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
// Bench for data_bus_arbiter (AW=DW=16, MAX_STARVE=4, MAX_BURST=8) with a
// 256-word async-read RAM on the crossbar side.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_arbiter_if #(.AW(16), .DW(16)) bus ();

  data_bus_arbiter #(
    .AW(16), .DW(16), .MAX_STARVE(4), .MAX_BURST(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Crossbar-side RAM: reloaded with a known pattern whenever rst is high
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= {8'hC0, i[7:0]};
      mem[8'h20] <= 16'h1234;
    end else if (bus.s_wen) begin
      mem[bus.s_addr[7:0]] <= bus.s_wdata;
    end
  end
  assign bus.s_rdata = mem[bus.s_addr[7:0]];

  typedef struct {
    string       name;
    logic        rst;
    logic        m0_req;
    logic        m0_wen;
    logic [15:0] m0_addr;
    logic [15:0] m0_wdata;
    logic        m1_req;
    logic        m1_lock;
    logic        m1_wen;
    logic [15:0] m1_addr;
    logic [15:0] m1_wdata;
    logic        exp_gnt1;
    logic        exp_stall;
    logic        chk_m0_rd;
    logic [15:0] exp_m0_rdata;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb [$];
  logic        exp_rv   = 1'b0;
  logic        exp_zero = 1'b0;
  vec_t        tbl [$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n,
                              input logic q0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                              input logic q1, input logic l1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                              input logic g1, input logic st);
    vec_t v;
    v.name = n; v.rst = 1'b0;
    v.m0_req = q0; v.m0_wen = w0; v.m0_addr = a0; v.m0_wdata = d0;
    v.m1_req = q1; v.m1_lock = l1; v.m1_wen = w1; v.m1_addr = a1; v.m1_wdata = d1;
    v.exp_gnt1 = g1; v.exp_stall = st;
    v.chk_m0_rd = 1'b0; v.exp_m0_rdata = 16'h0;
    return v;
  endfunction

  function automatic vec_t idle(input string n);
    return mk(n, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endfunction

  // Drive one cycle, check at the falling edge, then advance past the rising edge
  task automatic run_vec(input vec_t v);
    logic exp_g0;
    logic exp_wen;
    rst          = v.rst;
    bus.m0_req   = v.m0_req;  bus.m0_wen  = v.m0_wen;  bus.m0_addr = v.m0_addr; bus.m0_wdata = v.m0_wdata;
    bus.m1_req   = v.m1_req;  bus.m1_lock = v.m1_lock; bus.m1_wen  = v.m1_wen;
    bus.m1_addr  = v.m1_addr; bus.m1_wdata = v.m1_wdata;
    @(negedge clk);
    exp_g0  = v.m0_req & ~v.exp_stall;
    exp_wen = (v.exp_gnt1 & v.m1_wen) | (exp_g0 & v.m0_wen);
    chk1({v.name, "/m1_gnt"}, bus.m1_gnt, v.exp_gnt1);
    chk1({v.name, "/m0_stall"}, bus.m0_stall, v.exp_stall);
    chk1({v.name, "/s_wen"}, bus.s_wen, exp_wen);
    if (v.exp_gnt1 || exp_g0)
      chk16({v.name, "/s_addr"}, bus.s_addr, v.exp_gnt1 ? v.m1_addr : v.m0_addr);
    if (exp_wen)
      chk16({v.name, "/s_wdata"}, bus.s_wdata, v.exp_gnt1 ? v.m1_wdata : v.m0_wdata);
    if (v.chk_m0_rd)
      chk16({v.name, "/m0_rdata"}, bus.m0_rdata, v.exp_m0_rdata);
    chk1({v.name, "/m1_rvalid"}, bus.m1_rvalid, exp_rv);
    if (exp_rv && sb.size() > 0)
      chk16({v.name, "/m1_rdata"}, bus.m1_rdata, sb.pop_front());
    if (exp_zero)
      chk16({v.name, "/m1_rdata_rst"}, bus.m1_rdata, 16'h0);
    if (v.rst) begin
      sb.delete();
      exp_rv   = 1'b0;
      exp_zero = 1'b1;
    end else begin
      exp_zero = 1'b0;
      if (v.exp_gnt1 && !v.m1_wen) begin
        sb.push_back(mem[v.m1_addr[7:0]]);
        exp_rv = 1'b1;
      end else begin
        exp_rv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [15:0] a;
    logic        g;

    bus.m0_req = 1'b0; bus.m0_wen = 1'b0; bus.m0_addr = 16'h0; bus.m0_wdata = 16'h0;
    bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_wen = 1'b0;
    bus.m1_addr = 16'h0; bus.m1_wdata = 16'h0;

    // Table: CPU-only, DMA-only, contention, DMA write/readback
    v = mk("cpu_wr", 1'b1, 1'b1, 16'h4010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tbl.push_back(v);
    v = mk("cpu_rd", 1'b1, 1'b0, 16'h4010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    v.chk_m0_rd = 1'b1; v.exp_m0_rdata = 16'hBEEF;
    tbl.push_back(v);
    tbl.push_back(mk("dma_rd", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h4020, 16'h0, 1'b1, 1'b0));
    tbl.push_back(idle("dma_rd_ret"));
    for (int i = 0; i < 12; i++) begin
      g = (i == 4) || (i == 9);
      tbl.push_back(mk($sformatf("cont%0d", i), 1'b1, 1'b0, 16'h4030, 16'h0,
                       1'b1, 1'b0, 1'b0, 16'h4040, 16'h0, g, g));
    end
    tbl.push_back(idle("cont_end"));
    tbl.push_back(mk("dma_wr", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h4050, 16'h5A5A, 1'b1, 1'b0));
    tbl.push_back(mk("dma_rb", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h4050, 16'h0, 1'b1, 1'b0));
    tbl.push_back(idle("dma_rb_ret"));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst/m1_rvalid", bus.m1_rvalid, 1'b0);
    chk16("rst/m1_rdata", bus.m1_rdata, 16'h0);
    chk1("rst/m1_gnt", bus.m1_gnt, 1'b0);
    chk1("rst/m0_stall", bus.m0_stall, 1'b0);
    chk1("rst/s_wen", bus.s_wen, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Locked burst: 8 DMA beats, then the CPU wins with starve_cnt back at 0
    run_vec(mk("burst0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4060, 16'h0, 1'b1, 1'b0));
    for (int i = 1; i < 10; i++) begin
      a = 16'h4060 + 16'(i);
      g = (i < 8);
      run_vec(mk($sformatf("burst%0d", i), 1'b1, 1'b0, 16'h4030, 16'h0,
                 1'b1, 1'b1, 1'b0, a, 16'h0, g, g));
    end
    run_vec(idle("burst_end"));

    // Burst early release after 3 beats; the CPU write is held off for one cycle
    run_vec(mk("rel0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4061, 16'h0, 1'b1, 1'b0));
    run_vec(mk("rel1", 1'b1, 1'b0, 16'h4030, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4062, 16'h0, 1'b1, 1'b1));
    run_vec(mk("rel2", 1'b1, 1'b0, 16'h4030, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4063, 16'h0, 1'b1, 1'b1));
    run_vec(mk("rel3", 1'b1, 1'b1, 16'h4070, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1));
    run_vec(mk("rel4", 1'b1, 1'b1, 16'h4070, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0));
    v = mk("rel5", 1'b1, 1'b0, 16'h4070, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    v.chk_m0_rd = 1'b1; v.exp_m0_rdata = 16'h7777;
    run_vec(v);
    run_vec(idle("rel_end"));

    // Reset in beat 4 of a locked read burst
    run_vec(mk("rb0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4064, 16'h0, 1'b1, 1'b0));
    run_vec(mk("rb1", 1'b1, 1'b0, 16'h4030, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4065, 16'h0, 1'b1, 1'b1));
    run_vec(mk("rb2", 1'b1, 1'b0, 16'h4030, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4066, 16'h0, 1'b1, 1'b1));
    v = mk("rb3", 1'b1, 1'b0, 16'h4030, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4067, 16'h0, 1'b1, 1'b1);
    v.rst = 1'b1;
    run_vec(v);
    run_vec(mk("rb4", 1'b1, 1'b0, 16'h4030, 16'h0, 1'b1, 1'b1, 1'b0, 16'h4068, 16'h0, 1'b0, 1'b0));
    run_vec(idle("rb_end"));

    chk1("sb_empty", sb.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
